div_sequencer: RTL

- Multi-cycle controller and iterative datapath for the RV64M divide/remainder group: div, divu, rem, remu, divw, divuw, remw, remuw.
- Sits beside the single-cycle ALU. The control unit raises in_valid for a divide-class instruction, and the block holds busy high to stall PC update and register writeback until the result is delivered.
- Implements radix-2 restoring division, one quotient bit per cycle, with special cases resolved at issue.

---
 rtl/div_pkg.sv | 27 ++
 rtl/div_step.sv | 36 +++
 rtl/div_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared op-field positions, FSM encoding and sizing helper
//               for the iterative RV64M divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int OP_WORD = 2;
    localparam int OP_UNS  = 1;
    localparam int OP_REM  = 0;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t FIX  = 2'd2;
    localparam state_t DONE = 2'd3;

    // Wide enough to hold the full iteration count XLEN itself.
    function automatic int cnt_width(input int xlen);
        return $clog2(xlen) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One radix-2 restoring division step: shift {rem,quo} left and
//               keep the trial subtraction when it does not go negative.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] rem_nxt,
    output logic [XLEN-1:0] quo_nxt
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    // One extra bit: the shifted remainder can reach 2*dvs-1.
    assign w_shift = {rem, quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, dvs};

    always_comb begin
        if (!w_diff[XLEN]) begin
            rem_nxt = w_diff[XLEN-1:0];
            quo_nxt = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_nxt = w_shift[XLEN-1:0];
            quo_nxt = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : div_sequencer
// Description : Multi-cycle RV64M div/rem controller; resolves special cases
//               at issue, otherwise iterates one quotient bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module div_sequencer
    import div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);

    localparam int HW = XLEN / 2;
    localparam int c_cnt_w = cnt_width(XLEN);
    localparam logic [c_cnt_w-1:0] c_cnt_x = c_cnt_w'(XLEN);
    localparam logic [c_cnt_w-1:0] c_cnt_h = c_cnt_w'(HW);
    localparam logic [XLEN-1:0] c_min_x = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] c_min_h = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [XLEN-1:0]     r_rem;
    logic [XLEN-1:0]     r_quo;
    logic [XLEN-1:0]     r_dvs;
    logic                r_is_word;
    logic                r_is_rem;
    logic                r_q_neg;
    logic                r_r_neg;
    logic [XLEN-1:0]     r_result;

    logic                w_accept;
    logic                w_is_word;
    logic                w_signed;
    logic [XLEN-1:0]     w_a;
    logic [XLEN-1:0]     w_b;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;
    logic                w_div_zero;
    logic                w_ovf;
    logic                w_special;
    logic [XLEN-1:0]     w_spec_sel;
    logic [XLEN-1:0]     w_q_fix;
    logic [XLEN-1:0]     w_r_fix;
    logic [XLEN-1:0]     w_fix_sel;
    logic [XLEN-1:0]     w_rem_nxt;
    logic [XLEN-1:0]     w_quo_nxt;

    function automatic logic [XLEN-1:0] word_ext(input logic is_word,
                                                 input logic [XLEN-1:0] v);
        return is_word ? {{HW{v[HW-1]}}, v[HW-1:0]} : v;
    endfunction

    assign busy      = (r_state != IDLE);
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_result = r_result;

    assign w_accept  = in_valid && (r_state == IDLE) && !flush;
    assign w_is_word = in_op[OP_WORD];
    assign w_signed  = !in_op[OP_UNS];

    always_comb begin
        w_a = in_src1;
        w_b = in_src2;
        if (w_is_word) begin
            w_a = {{HW{w_signed & in_src1[HW-1]}}, in_src1[HW-1:0]};
            w_b = {{HW{w_signed & in_src2[HW-1]}}, in_src2[HW-1:0]};
        end
    end

    assign w_a_neg    = w_signed && w_a[XLEN-1];
    assign w_b_neg    = w_signed && w_b[XLEN-1];
    assign w_abs_a    = w_a_neg ? (~w_a + 1'b1) : w_a;
    assign w_abs_b    = w_b_neg ? (~w_b + 1'b1) : w_b;
    assign w_div_zero = (w_b == '0);
    assign w_ovf      = w_signed && (w_a == (w_is_word ? c_min_h : c_min_x)) &&
                        (w_b == {XLEN{1'b1}});
    assign w_special  = w_div_zero || w_ovf;

    always_comb begin
        w_spec_sel = '0;
        if (w_div_zero)
            w_spec_sel = in_op[OP_REM] ? w_a : {XLEN{1'b1}};
        else if (w_ovf)
            w_spec_sel = in_op[OP_REM] ? '0 : w_a;
    end

    assign w_q_fix   = r_q_neg ? (~r_quo + 1'b1) : r_quo;
    assign w_r_fix   = r_r_neg ? (~r_rem + 1'b1) : r_rem;
    assign w_fix_sel = r_is_rem ? w_r_fix : w_q_fix;

    div_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem     (r_rem),
        .quo     (r_quo),
        .dvs     (r_dvs),
        .rem_nxt (w_rem_nxt),
        .quo_nxt (w_quo_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: if (w_accept) w_state_nxt = w_special ? DONE : CALC;
                CALC: if (r_cnt == c_cnt_w'(1)) w_state_nxt = FIX;
                FIX:  w_state_nxt = DONE;
                DONE: if (out_ready) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_is_word <= 1'b0;
            r_is_rem  <= 1'b0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_result  <= '0;
        end else if (w_accept) begin
            r_is_word <= w_is_word;
            r_is_rem  <= in_op[OP_REM];
            r_q_neg   <= w_a_neg ^ w_b_neg;
            r_r_neg   <= w_a_neg;
            r_dvs     <= w_abs_b;
            r_rem     <= '0;
            // Word dividends are pre-aligned so their MSB leaves first.
            r_quo     <= w_is_word ? (w_abs_a << HW) : w_abs_a;
            r_cnt     <= w_is_word ? c_cnt_h : c_cnt_x;
            if (w_special)
                r_result <= word_ext(w_is_word, w_spec_sel);
        end else if (!flush && r_state == CALC) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt - c_cnt_w'(1);
        end else if (!flush && r_state == FIX) begin
            r_result <= word_ext(r_is_word, w_fix_sel);
        end
    end

endmodule
`default_nettype wire
